// File: rtl/prescaled_updown_counter.sv
// Prescaled up/down counter: a free-running prescaler produces a one-cycle
// tick event that advances a modulus-N counter with wrap or saturate modes,
// synchronous clamped load, terminal-count pulse and an at-limit level.
module prescaled_updown_counter #(
  parameter int unsigned width           = 8,
  parameter int unsigned modulus         = 256,
  parameter int unsigned cycles_per_tick = 25000000
) (
  input  logic             clock,
  input  logic             clear_n,
  input  logic             count,
  input  logic             up,
  input  logic             saturate,
  input  logic             load,
  input  logic [width-1:0] load_value,
  output logic [width-1:0] q,
  output logic             tick,
  output logic             terminal,
  output logic             at_limit
);

  localparam int unsigned pre_w = (cycles_per_tick > 1) ? $clog2(cycles_per_tick) : 1;
  localparam int unsigned cw    = width + 1;
  localparam logic [pre_w-1:0] pre_last = pre_w'(cycles_per_tick - 1);
  localparam logic [cw-1:0]    q_max    = cw'(modulus - 1);

  // Reject parameter sets the counter cannot represent.
  if (modulus < 2 || 64'(modulus) > (64'(1) << width)) begin : g_bad_modulus
    $error("prescaled_updown_counter: modulus must be in 2..2**width");
  end
  if (cycles_per_tick < 1) begin : g_bad_prescale
    $error("prescaled_updown_counter: cycles_per_tick must be >= 1");
  end

  logic [pre_w-1:0] pre;
  logic [pre_w-1:0] pre_nxt;
  logic             tick_ev;
  logic [cw-1:0]    q_ext;
  logic [cw-1:0]    lv_ext;
  logic [cw-1:0]    q_nxt_ext;
  logic             at_top;
  logic             at_bot;
  logic             term_nxt;
  logic             lim_nxt;

  // One extra bit keeps the modulus-1 compare safe when modulus == 2**width.
  assign q_ext  = {1'b0, q};
  assign lv_ext = {1'b0, load_value};
  assign at_top = (q_ext == q_max);
  assign at_bot = (q_ext == '0);

  // Prescaler next state; load restarts the prescale period and suppresses the tick.
  always_comb begin
    pre_nxt = pre;
    tick_ev = 1'b0;
    if (load) begin
      pre_nxt = '0;
    end else if (count) begin
      if (pre == pre_last) begin
        pre_nxt = '0;
        tick_ev = 1'b1;
      end else begin
        pre_nxt = pre + pre_w'(1);
      end
    end
  end

  // Counter next state, terminal pulse and at-limit level.
  always_comb begin
    q_nxt_ext = q_ext;
    term_nxt  = 1'b0;
    if (load) begin
      q_nxt_ext = (lv_ext > q_max) ? q_max : lv_ext;
    end else if (tick_ev) begin
      if (up) begin
        term_nxt = at_top;
        if (!at_top) begin
          q_nxt_ext = q_ext + cw'(1);
        end else if (!saturate) begin
          q_nxt_ext = '0;
        end
      end else begin
        term_nxt = at_bot;
        if (!at_bot) begin
          q_nxt_ext = q_ext - cw'(1);
        end else if (!saturate) begin
          q_nxt_ext = q_max;
        end
      end
    end
    lim_nxt = (up && (q_nxt_ext == q_max)) || (!up && (q_nxt_ext == '0));
  end

  // State and registered outputs.
  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n) begin
      pre      <= '0;
      q        <= '0;
      tick     <= 1'b0;
      terminal <= 1'b0;
      at_limit <= 1'b0;
    end else begin
      pre      <= pre_nxt;
      q        <= q_nxt_ext[width-1:0];
      tick     <= tick_ev;
      terminal <= term_nxt;
      at_limit <= lim_nxt;
    end
  end

endmodule

// File: tb/tb_prescaled_updown_counter.sv
// Bench for prescaled_updown_counter: two instances (modulus 12 and 256)
// share stimulus; expected tick results are queued by the stimulus thread and
// popped by a monitor each time the DUTs present a tick.
module tb_prescaled_updown_counter;

  typedef struct {
    int unsigned cyc;
    int unsigned qa;
    bit          terma;
    bit          lima;
    int unsigned qb;
    bit          termb;
    bit          limb;
  } exp_t;

  logic       clock = 1'b0;
  logic       clear_n;
  logic       count;
  logic       up;
  logic       saturate;
  logic       load;
  logic [7:0] load_value;

  logic [7:0] q_a, q_b;
  logic       tick_a, tick_b, terminal_a, terminal_b, at_limit_a, at_limit_b;

  int          checks = 0;
  int          errors = 0;
  int unsigned cyc = 0;
  logic        prev_tick = 1'b0;
  exp_t        sb[$];

  int unsigned c0, l0, t0, r0;

  prescaled_updown_counter #(.width(8), .modulus(12), .cycles_per_tick(10)) u_dut_a (
    .clock(clock), .clear_n(clear_n), .count(count), .up(up), .saturate(saturate),
    .load(load), .load_value(load_value), .q(q_a), .tick(tick_a),
    .terminal(terminal_a), .at_limit(at_limit_a)
  );

  prescaled_updown_counter #(.width(8), .modulus(256), .cycles_per_tick(10)) u_dut_b (
    .clock(clock), .clear_n(clear_n), .count(count), .up(up), .saturate(saturate),
    .load(load), .load_value(load_value), .q(q_b), .tick(tick_b),
    .terminal(terminal_b), .at_limit(at_limit_b)
  );

  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push(int unsigned c, int unsigned qa, bit ta, bit la,
                      int unsigned qb, bit tb, bit lb);
    exp_t e;
    e.cyc = c; e.qa = qa; e.terma = ta; e.lima = la;
    e.qb = qb; e.termb = tb; e.limb = lb;
    sb.push_back(e);
  endtask

  task automatic wait_cyc(int unsigned target);
    while (cyc < target) @(negedge clock);
  endtask

  // Monitor: pop and compare on every tick; terminal must stay low otherwise.
  always @(negedge clock) begin
    exp_t e;
    chk("tick_match", 32'(tick_b), 32'(tick_a));
    if (tick_a) begin
      chk("tick_width", 32'(prev_tick), 32'd0);
      if (sb.size() == 0) begin
        chk("unexpected_tick", 32'(sb.size()), 32'd1);
      end else begin
        e = sb.pop_front();
        chk("tick_cycle", cyc, e.cyc);
        chk("q_a", 32'(q_a), e.qa);
        chk("terminal_a", 32'(terminal_a), 32'(e.terma));
        chk("at_limit_a", 32'(at_limit_a), 32'(e.lima));
        chk("q_b", 32'(q_b), e.qb);
        chk("terminal_b", 32'(terminal_b), 32'(e.termb));
        chk("at_limit_b", 32'(at_limit_b), 32'(e.limb));
      end
    end else begin
      chk("terminal_idle", 32'({terminal_a, terminal_b}), 32'd0);
    end
    prev_tick <= tick_a;
  end

  initial begin
    clear_n = 1'b0; count = 1'b0; up = 1'b0; saturate = 1'b0;
    load = 1'b0; load_value = '0;
    repeat (3) @(negedge clock);
    chk("reset_q_a", 32'(q_a), 32'd0);
    chk("reset_q_b", 32'(q_b), 32'd0);
    chk("reset_tick", 32'(tick_a), 32'd0);
    clear_n = 1'b1;
    @(negedge clock);
    chk("post_reset_limit_down_a", 32'(at_limit_a), 32'd1);
    chk("post_reset_limit_down_b", 32'(at_limit_b), 32'd1);
    up = 1'b1;
    @(negedge clock);
    chk("limit_up_a", 32'(at_limit_a), 32'd0);
    chk("limit_up_b", 32'(at_limit_b), 32'd0);

    // Count up in wrap mode: modulus 12 wraps on the 12th tick.
    count = 1'b1;
    c0 = cyc;
    for (int k = 1; k <= 12; k++)
      push(c0 + 32'(10 * k), 32'(k % 12), k == 12, k == 11, 32'(k), 1'b0, 1'b0);
    wait_cyc(c0 + 120);

    // Saturate mode: hold at 11 with terminal on every tick at the limit.
    saturate = 1'b1;
    for (int j = 1; j <= 13; j++)
      push(c0 + 120 + 32'(10 * j), (j >= 11) ? 32'd11 : 32'(j), j >= 12, j >= 11,
           32'(12 + j), 1'b0, 1'b0);
    wait_cyc(c0 + 250);
    up = 1'b0;
    push(c0 + 260, 10, 1'b0, 1'b0, 24, 1'b0, 1'b0);
    wait_cyc(c0 + 260);

    // Load zero, then count down through the wrap.
    load = 1'b1; load_value = 8'd0; saturate = 1'b0;
    @(negedge clock);
    load = 1'b0;
    l0 = cyc;
    chk("load0_q_a", 32'(q_a), 32'd0);
    chk("load0_q_b", 32'(q_b), 32'd0);
    chk("load0_limit_a", 32'(at_limit_a), 32'd1);
    chk("load0_limit_b", 32'(at_limit_b), 32'd1);
    push(l0 + 10, 11, 1'b1, 1'b0, 255, 1'b1, 1'b0);
    push(l0 + 20, 10, 1'b0, 1'b0, 254, 1'b0, 1'b0);
    wait_cyc(l0 + 29);

    // Load 200 coinciding with a tick event: clamp on modulus 12, no tick.
    load = 1'b1; load_value = 8'd200;
    @(negedge clock);
    load = 1'b0;
    chk("load200_q_a", 32'(q_a), 32'd11);
    chk("load200_q_b", 32'(q_b), 32'd200);
    chk("load200_tick", 32'(tick_a), 32'd0);
    t0 = l0 + 40;
    push(t0, 10, 1'b0, 1'b0, 199, 1'b0, 1'b0);
    wait_cyc(t0 + 5);

    // Pause the prescaler at pre=5 for 7 cycles.
    count = 1'b0;
    wait_cyc(t0 + 12);
    count = 1'b1;
    push(t0 + 17, 9, 1'b0, 1'b0, 198, 1'b0, 1'b0);
    push(t0 + 27, 8, 1'b0, 1'b0, 197, 1'b0, 1'b0);
    wait_cyc(t0 + 27);

    // Asynchronous clear while tick is high.
    #2 clear_n = 1'b0;
    #1;
    chk("async_q_a", 32'(q_a), 32'd0);
    chk("async_q_b", 32'(q_b), 32'd0);
    chk("async_tick", 32'({tick_a, tick_b}), 32'd0);
    repeat (2) @(negedge clock);
    clear_n = 1'b1;
    r0 = cyc;
    push(r0 + 10, 11, 1'b1, 1'b0, 255, 1'b1, 1'b0);
    push(r0 + 20, 10, 1'b0, 1'b0, 254, 1'b0, 1'b0);
    wait_cyc(r0 + 25);

    chk("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
